// File: rtl/ecc_apb_master_if.sv
// ecc_apb_master_if: command/response port and APB bus of the ECC APB initiator.
// The master modport is the initiator's view; the slave modport is the view of
// whatever drives commands and models the APB slave.
interface ecc_apb_master_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [AMBA_ADDR_WIDTH-1:0] req_addr;
    logic [AMBA_WORD-1:0]       req_wdata;
    logic                       rsp_valid;
    logic                       rsp_write;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       busy;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PWRITE;
    logic                       PSEL;
    logic                       PENABLE;
    logic [AMBA_WORD-1:0]       PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, busy,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/ecc_apb_master.sv
// ecc_apb_master: queues read/write commands in a small FIFO and runs each one
// as a two-phase APB transfer (SETUP, ACCESS) towards the ECC_ENC_DEC slave.
// One response pulse follows every ACCESS phase; reads return PRDATA.
module ecc_apb_master #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int CMD_DEPTH       = 4
) (
    input  logic             clk,
    input  logic             rst,
    ecc_apb_master_if.master bus
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(CMD_DEPTH);

    typedef struct packed {
        logic                       write;
        logic [AMBA_ADDR_WIDTH-1:0] addr;
        logic [AMBA_WORD-1:0]       wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                     state_q, state_d;
    cmd_t                       mem_q [CMD_DEPTH];
    cmd_t                       push_cmd, head_cmd;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]             count_q, count_d;
    logic                       push, pop, fifo_empty, fifo_full;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
    logic                       pwrite_q, pwrite_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_write_q, rsp_write_d;
    logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign push       = bus.req_valid && !fifo_full;
    assign push_cmd   = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
    assign head_cmd   = mem_q[rd_ptr_q];

    // Next-state logic: FIFO pointers, APB sequencing and response capture.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        pop         = 1'b0;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // The slave has no PREADY, so the transfer completes at this edge.
                rsp_valid_d = 1'b1;
                rsp_write_d = pwrite_q;
                rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                penable_d   = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end else begin
                    psel_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // Address, data and direction only move when a command is popped.
        if (pop) begin
            paddr_d  = head_cmd.addr;
            pwdata_d = head_cmd.wdata;
            pwrite_d = head_cmd.write;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Control and bus registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Command storage written on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; emptiness is tracked by count_q, so stale entries are never read.
        if (push) begin
            mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.busy      = !fifo_empty || (state_q != IDLE);
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
